// File: rtl/multi_pwm.sv
// -----------------------------------------------------------------------------
// multi_pwm
//   N_CH independent PWM channels that share one prescaler and one frame
//   counter. Each channel has a shadow pulse width written through a simple
//   load strobe. The shadow value is copied into the active width only at a
//   frame boundary, so a channel never changes duty mid-frame.
//
// Parameters
//   N_CH    number of channels (1..16)
//   W_BITS  width of pulse-width, period and counter values
//   DIV     clk cycles per counter tick (2..256)
//
// Ports
//   clk          core clock, rising edge
//   reset        asynchronous active-low reset, release synchronised to clk
//   en           enables the prescaler and the frame counter
//   load         one-cycle write strobe for shadow[ch_sel]
//   ch_sel       channel addressed by load
//   W            pulse width in ticks, written on load
//   PER          frame period in ticks, sampled at each frame boundary
//   load_ack     one-cycle acknowledge of an accepted load
//   load_err     one-cycle flag for a load to a channel index >= N_CH
//   pending      per channel: shadow written but not yet applied
//   tick         prescaler enable pulse
//   cnt          frame counter
//   frame_start  one-cycle pulse in the first cycle of a frame (cnt = 0)
//   signal       PWM outputs, registered
//   PWMset       one-cycle pulse, one cycle after a rising edge of signal
//   PWMreset     one-cycle pulse, one cycle after a falling edge of signal
// -----------------------------------------------------------------------------
module multi_pwm #(
   parameter int N_CH   = 4,
   parameter int W_BITS = 13,
   parameter int DIV    = 25
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      en,
   input  logic                                      load,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ch_sel,
   input  logic [W_BITS-1:0]                         W,
   input  logic [W_BITS-1:0]                         PER,
   output logic                                      load_ack,
   output logic                                      load_err,
   output logic [N_CH-1:0]                           pending,
   output logic                                      tick,
   output logic [W_BITS-1:0]                         cnt,
   output logic                                      frame_start,
   output logic [N_CH-1:0]                           signal,
   output logic [N_CH-1:0]                           PWMset,
   output logic [N_CH-1:0]                           PWMreset
);

   localparam int                CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int                PS_W    = $clog2(DIV);
   localparam logic [PS_W-1:0]   PS_LAST = PS_W'(DIV - 1);
   localparam logic [W_BITS-1:0] P_MIN   = W_BITS'(2);
   localparam logic [W_BITS-1:0] ONE     = W_BITS'(1);

   // Reset synchroniser: assertion reaches every flop at once through the
   // async clear, release is seen by the rest of the block two edges later.
   logic rst_meta;
   logic rst_sync;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_meta <= 1'b0;
         rst_sync <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_sync <= rst_meta;
      end
   end

   // ---------------------------------------------------------------------------
   // Prescaler, frame counter and active period
   // ---------------------------------------------------------------------------
   logic [PS_W-1:0]   presc;
   logic [W_BITS-1:0] per_act;   // active period P, already saturated to >= 2
   logic [W_BITS-1:0] per_next;
   logic              boundary;

   assign tick     = en && (presc == PS_LAST);
   assign boundary = tick && (cnt == per_act - ONE);
   assign per_next = (PER < P_MIN) ? P_MIN : PER;

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         presc       <= '0;
         cnt         <= '0;
         per_act     <= '1;
         frame_start <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values of its sources, independent of statement order.
         if (en) begin
            presc <= (presc == PS_LAST) ? '0 : presc + PS_W'(1);
         end
         if (tick) begin
            cnt <= boundary ? '0 : cnt + ONE;
         end
         if (boundary) begin
            per_act <= per_next;
         end
         frame_start <= boundary;
      end
   end

   // ---------------------------------------------------------------------------
   // Load interface, shadow and active widths
   // ---------------------------------------------------------------------------
   logic [W_BITS-1:0] shadow [N_CH];
   logic [W_BITS-1:0] active [N_CH];
   logic              ch_valid;

   assign ch_valid = 32'(ch_sel) < N_CH;

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         // NOTE: these arrays hold architectural state that must read zero
         // after reset, so they are cleared element by element here rather
         // than left as uninitialised storage.
         for (int i = 0; i < N_CH; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         pending  <= '0;
         load_ack <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_ack <= load && ch_valid;
         load_err <= load && !ch_valid;
         for (int i = 0; i < N_CH; i++) begin
            // active takes the pre-write shadow, so a load landing in the
            // boundary cycle waits for the next boundary with pending held.
            if (boundary && pending[i]) begin
               active[i] <= shadow[i];
            end
            if (load && ch_valid && (ch_sel == CH_W'(i))) begin
               shadow[i]  <= W;
               pending[i] <= 1'b1;
            end else if (boundary) begin
               pending[i] <= 1'b0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // PWM compare and edge detection
   // ---------------------------------------------------------------------------
   logic [N_CH-1:0] sig_cmp;
   logic [N_CH-1:0] sig_prev;

   always_comb begin
      // NOTE: default first so every bit is assigned on every pass and no
      // latch is inferred.
      sig_cmp = '0;
      for (int i = 0; i < N_CH; i++) begin
         sig_cmp[i] = cnt < active[i];
      end
   end

   always_ff @(posedge clk or negedge rst_sync) begin
      if (!rst_sync) begin
         signal   <= '0;
         sig_prev <= '0;
         PWMset   <= '0;
         PWMreset <= '0;
      end else begin
         signal   <= sig_cmp;
         sig_prev <= signal;
         PWMset   <= signal & ~sig_prev;
         PWMreset <= ~signal & sig_prev;
      end
   end

endmodule

// File: tb/tb_multi_pwm.sv
// -----------------------------------------------------------------------------
// tb_multi_pwm
//   Directed and randomised stimulus for multi_pwm (N_CH=3, W_BITS=8, DIV=4).
//   A behavioural model tracks prescaler position, frame position, shadow and
//   active widths as plain integers and predicts every output each cycle;
//   duty-cycle windows add frame-level checks on top.
// -----------------------------------------------------------------------------
module tb_multi_pwm;

   localparam int N_CH   = 3;
   localparam int W_BITS = 8;
   localparam int DIV    = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              en;
   logic              load;
   logic [1:0]        ch_sel;
   logic [W_BITS-1:0] W;
   logic [W_BITS-1:0] PER;
   logic              load_ack;
   logic              load_err;
   logic [N_CH-1:0]   pending;
   logic              tick;
   logic [W_BITS-1:0] cnt;
   logic              frame_start;
   logic [N_CH-1:0]   signal;
   logic [N_CH-1:0]   PWMset;
   logic [N_CH-1:0]   PWMreset;

   int total = 0;
   int bad   = 0;

   multi_pwm #(.N_CH(N_CH), .W_BITS(W_BITS), .DIV(DIV)) dut (
      .clk         (clk),
      .reset       (reset),
      .en          (en),
      .load        (load),
      .ch_sel      (ch_sel),
      .W           (W),
      .PER         (PER),
      .load_ack    (load_ack),
      .load_err    (load_err),
      .pending     (pending),
      .tick        (tick),
      .cnt         (cnt),
      .frame_start (frame_start),
      .signal      (signal),
      .PWMset      (PWMset),
      .PWMreset    (PWMreset)
   );

   always #5 clk = ~clk;

   // ---------------------------------------------------------------------------
   // Reference model
   // ---------------------------------------------------------------------------
   int              m_pre;
   int              m_cnt;
   int              m_p;
   int              m_shadow [N_CH];
   int              m_active [N_CH];
   logic [N_CH-1:0] m_pending;
   logic [N_CH-1:0] m_sig;
   logic [N_CH-1:0] m_prev;
   logic [N_CH-1:0] m_set;
   logic [N_CH-1:0] m_rst;
   logic            m_ack;
   logic            m_err;
   logic            m_fs;
   logic            last_tick;

   function void model_reset();
      m_pre = 0;
      m_cnt = 0;
      m_p   = (1 << W_BITS) - 1;
      for (int i = 0; i < N_CH; i++) begin
         m_shadow[i] = 0;
         m_active[i] = 0;
      end
      m_pending = '0;
      m_sig     = '0;
      m_prev    = '0;
      m_set     = '0;
      m_rst     = '0;
      m_ack     = 1'b0;
      m_err     = 1'b0;
      m_fs      = 1'b0;
   endfunction

   // One clock edge of the behaviour, computed from the inputs present at it.
   function void model_edge();
      logic [N_CH-1:0] new_sig;
      logic            tk;
      logic            bnd;
      logic            valid;
      if (!reset) begin
         model_reset();
         return;
      end
      tk  = en && (m_pre == DIV - 1);
      bnd = tk && (m_cnt == m_p - 1);
      for (int i = 0; i < N_CH; i++) begin
         new_sig[i] = m_cnt < m_active[i];
      end
      m_set  = m_sig & ~m_prev;
      m_rst  = ~m_sig & m_prev;
      m_prev = m_sig;
      m_sig  = new_sig;
      m_fs   = bnd;
      valid  = load && (int'(ch_sel) < N_CH);
      m_ack  = valid;
      m_err  = load && !valid;
      if (bnd) begin
         for (int i = 0; i < N_CH; i++) begin
            if (m_pending[i]) begin
               m_active[i]  = m_shadow[i];
               m_pending[i] = 1'b0;
            end
         end
         m_p = (int'(PER) < 2) ? 2 : int'(PER);
      end
      if (valid) begin
         m_shadow[int'(ch_sel)]  = int'(W);
         m_pending[int'(ch_sel)] = 1'b1;
      end
      if (tk) begin
         m_cnt = bnd ? 0 : m_cnt + 1;
      end
      if (en) begin
         m_pre = (m_pre + 1) % DIV;
      end
   endfunction

   // ---------------------------------------------------------------------------
   // Checking helpers
   // ---------------------------------------------------------------------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("cnt",         32'(cnt),         32'(m_cnt));
      check("frame_start", 32'(frame_start), 32'(m_fs));
      check("signal",      32'(signal),      32'(m_sig));
      check("PWMset",      32'(PWMset),      32'(m_set));
      check("PWMreset",    32'(PWMreset),    32'(m_rst));
      check("set_rst_excl", 32'(PWMset & PWMreset), 32'(0));
      check("pending",     32'(pending),     32'(m_pending));
      check("load_ack",    32'(load_ack),    32'(m_ack));
      check("load_err",    32'(load_err),    32'(m_err));
   endtask

   // Inputs are already driven; check tick before the edge, then the
   // registered outputs 1 time unit after it.
   task automatic step();
      #1;
      last_tick = tick;
      check("tick", 32'(tick), 32'(en && reset && (m_pre == DIV - 1)));
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_fs(input int limit);
      int k;
      k = 0;
      while (frame_start !== 1'b1 && k < limit) begin
         step();
         k++;
      end
      check("wait_frame_start", 32'(frame_start), 32'(1));
   endtask

   task automatic window(input int n, input int ch, output int hi, output int sets, output int rsts);
      hi   = 0;
      sets = 0;
      rsts = 0;
      for (int i = 0; i < n; i++) begin
         hi   += int'(signal[ch]);
         sets += int'(PWMset[ch]);
         rsts += int'(PWMreset[ch]);
         step();
      end
   endtask

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      int hi, sets, rsts, hi2, s2, r2, k, first;
      logic [W_BITS-1:0] cnt_save;
      logic [N_CH-1:0]   sig_save;

      // Reset with random inputs
      reset  = 1'b1;
      en     = 1'b0;
      load   = 1'b0;
      ch_sel = '0;
      W      = '0;
      PER    = '0;
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      for (int i = 0; i < 4; i++) begin
         en     = 1'($urandom);
         load   = 1'($urandom);
         ch_sel = 2'($urandom);
         W      = W_BITS'($urandom);
         PER    = W_BITS'($urandom);
         step();
      end
      reset = 1'b1;
      en    = 1'b0;
      load  = 1'b0;
      idle(3);
      check("cnt_after_reset", 32'(cnt), 32'(0));

      // ch0 W=3, PER=10
      PER    = 8'd10;
      en     = 1'b1;
      load   = 1'b1;
      ch_sel = 2'd0;
      W      = 8'd3;
      step();
      load = 1'b0;
      check("ack_ch0", 32'(load_ack), 32'(1));
      check("pend_ch0", 32'(pending[0]), 32'(1));
      wait_fs(1100);
      check("pend_ch0_applied", 32'(pending[0]), 32'(0));
      window(40, 0, hi, sets, rsts);
      check("duty_ch0_w3", 32'(hi), 32'(12));
      check("sets_ch0_w3", 32'(sets), 32'(1));
      check("rsts_ch0_w3", 32'(rsts), 32'(1));

      // ch1 W=0, ch2 W=12 (>= P)
      load   = 1'b1;
      ch_sel = 2'd1;
      W      = 8'd0;
      step();
      ch_sel = 2'd2;
      W      = 8'd12;
      step();
      load = 1'b0;
      wait_fs(50);
      idle(3);
      window(80, 1, hi, sets, rsts);
      window(80, 2, hi2, s2, r2);
      check("ch1_const_low", 32'(hi), 32'(0));
      check("ch1_no_edges", 32'(sets + rsts), 32'(0));
      check("ch2_const_high", 32'(hi2), 32'(80));
      check("ch2_no_edges", 32'(s2 + r2), 32'(0));

      // Load ch0 W=7 in the boundary cycle
      k = 0;
      while (!(m_pre == DIV - 1 && m_cnt == m_p - 1) && k < 200) begin
         step();
         k++;
      end
      check("reach_boundary", 32'(m_pre == DIV - 1 && m_cnt == m_p - 1), 32'(1));
      load   = 1'b1;
      ch_sel = 2'd0;
      W      = 8'd7;
      step();
      load = 1'b0;
      check("bnd_load_fs", 32'(frame_start), 32'(1));
      check("bnd_load_pend", 32'(pending[0]), 32'(1));
      window(39, 0, hi, sets, rsts);
      check("bnd_load_pend_held", 32'(pending[0]), 32'(1));
      window(1, 0, hi2, s2, r2);
      check("bnd_frame_old_duty", 32'(hi + hi2), 32'(12));
      check("next_frame_fs", 32'(frame_start), 32'(1));
      check("next_frame_pend_clr", 32'(pending[0]), 32'(0));
      window(40, 0, hi, sets, rsts);
      check("duty_ch0_w7", 32'(hi), 32'(28));
      check("edges_ch0_w7", 32'(sets + rsts), 32'(2));

      // Invalid channel after a valid pending write to ch1
      load   = 1'b1;
      ch_sel = 2'd1;
      W      = 8'd5;
      step();
      ch_sel = 2'd3;
      W      = W_BITS'($urandom);
      step();
      load = 1'b0;
      check("err_ch3", 32'(load_err), 32'(1));
      check("no_ack_ch3", 32'(load_ack), 32'(0));
      check("pend_after_err", 32'(pending), 32'(3'b010));
      wait_fs(50);
      window(40, 1, hi, sets, rsts);
      check("duty_ch1_w5", 32'(hi), 32'(20));

      // Freeze mid-frame, then resume
      idle(13);
      en       = 1'b0;
      cnt_save = cnt;
      sig_save = signal;
      idle(20);
      check("freeze_cnt", 32'(cnt), 32'(cnt_save));
      check("freeze_signal", 32'(signal), 32'(sig_save));
      en = 1'b1;
      idle(30);

      // Reset mid-frame: immediate clear
      idle(7);
      reset = 1'b0;
      #1;
      model_reset();
      check_all();
      check("rst_clear_outputs", 32'({signal, PWMset, PWMreset, pending, cnt, tick, frame_start}), 32'(0));
      step();
      step();
      reset = 1'b1;
      en    = 1'b0;
      idle(3);
      en    = 1'b1;
      first = -1;
      for (int i = 0; i < 2 * DIV; i++) begin
         step();
         if (last_tick === 1'b1 && first < 0) first = i;
      end
      check("first_tick_delay", 32'(first), 32'(DIV - 1));

      // Randomised traffic against the model
      PER = 8'd4;
      wait_fs(1200);
      for (int i = 0; i < 400; i++) begin
         en     = ($urandom_range(0, 7) != 0);
         load   = ($urandom_range(0, 3) == 0);
         ch_sel = 2'($urandom_range(0, 3));
         W      = W_BITS'($urandom_range(0, 14));
         PER    = W_BITS'($urandom_range(0, 8));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
